// File: rtl/pipelined_mult_tree.sv
// pipelined_mult_tree: pipelined unsigned (optionally signed) WIDTH x WIDTH multiplier.
//   Ports: clk, rst_n (async active-low); in_valid/in_ready/x/y operand side;
//   out_valid/out_ready/o (2*WIDTH product) result side.
//   Build macro PIPELINED_MULT_SIGNED_EN adds input sgn, which selects a
//   two's-complement product (Baugh-Wooley) for the operands it travels with.
//   AND-array partial products are reduced by rows of HA/FA (3:2) cells down to
//   two rows, then added; register ranks sit at evenly spaced tree levels and the
//   final rank holds the finished product.
module pipelined_mult_tree #(
    parameter int WIDTH  = 4,
    parameter int STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     x,
    input  logic [WIDTH-1:0]     y,
`ifdef PIPELINED_MULT_SIGNED_EN
    input  logic                 sgn,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   o
);
    localparam int PW = 2 * WIDTH;
    typedef logic [WIDTH-1:0][PW-1:0] rows_t;

    // rows left after l levels of 3:2 compression
    function automatic int tree_rows(int l);
        int n = WIDTH;
        for (int k = 0; k < l; k++)
            n = 2 * (n / 3) + n % 3;
        return n;
    endfunction

    function automatic int tree_levels();
        int n = WIDTH;
        int l = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            l++;
        end
        return l;
    endfunction

    localparam int LEVELS = tree_levels();

    // one tree level: each group of three rows becomes a sum row and a shifted
    // carry row; the one or two leftover rows pass through untouched
    function automatic rows_t csa(rows_t r, int n);
        rows_t t = '0;
        int g = n / 3;
        for (int i = 0; i < WIDTH / 3; i++)
            if (i < g) begin
                t[2*i]   = r[3*i] ^ r[3*i+1] ^ r[3*i+2];
                t[2*i+1] = ((r[3*i] & r[3*i+1]) | (r[3*i] & r[3*i+2]) | (r[3*i+1] & r[3*i+2])) << 1;
            end
        for (int p = 0; p < 2; p++)
            if (p < n % 3)
                t[2*g+p] = r[3*g+p];
        return t;
    endfunction

    logic                     sg;
    logic                     stall;
    logic [STAGES-1:0]        vld_d, vld_q;
    rows_t [STAGES-1:0]       rows_d, rows_q;
    rows_t                    pp, r, prev;

`ifdef PIPELINED_MULT_SIGNED_EN
    assign sg = sgn;
`else
    assign sg = 1'b0;
`endif

    assign out_valid = vld_q[STAGES-1];
    assign stall     = out_valid && !out_ready;
    assign in_ready  = !stall;
    // last rank keeps the product in row 0; gate it so idle output reads zero
    assign o         = out_valid ? rows_q[STAGES-1][0] : '0;

    always_comb begin
        pp     = '0;
        r      = '0;
        prev   = '0;
        rows_d = rows_q;
        // signed mode inverts the mixed-sign MSB partial products; the
        // correction constant 2^WIDTH + 2^(2*WIDTH-1) fits in row 0's empty top bits
        for (int i = 0; i < WIDTH; i++)
            for (int j = 0; j < WIDTH; j++)
                pp[i][i+j] = (x[j] & y[i]) ^ (sg & ((i == WIDTH - 1) != (j == WIDTH - 1)));
        if (sg) begin
            pp[0][WIDTH] = 1'b1;
            pp[0][PW-1]  = 1'b1;
        end
        prev = pp;
        // stage s runs tree levels ceil(s*L/S)+1 .. ceil((s+1)*L/S); the last
        // stage also does the carry-propagate add
        for (int s = 0; s < STAGES; s++) begin
            r = prev;
            for (int l = (s * LEVELS + STAGES - 1) / STAGES + 1;
                 l <= ((s + 1) * LEVELS + STAGES - 1) / STAGES; l++)
                r = csa(r, tree_rows(l - 1));
            if (s == STAGES - 1) begin
                r[0]         = r[0] + r[1];
                r[WIDTH-1:1] = '0;
            end
            if (!stall)
                rows_d[s] = r;
            prev = rows_q[s];
        end
        vld_d = stall ? vld_q : STAGES'({vld_q, in_valid});
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            vld_q  <= '0;
            rows_q <= '0;
        end else begin
            vld_q  <= vld_d;
            rows_q <= rows_d;
        end
endmodule

// File: doc/pipelined_mult_tree.md
Name: pipelined_mult_tree

Overview:
- Parametrised, pipelined unsigned integer multiplier; successor to the fixed 4-bit combinational partial-product/compressor-tree multiplier.
- Generates WIDTH x WIDTH AND-array partial products and reduces them through a half-adder/full-adder carry-save tree.
- Registers are placed at STAGES evenly spaced cut points, followed by a final carry-propagate add.
- Valid/ready handshake on both sides; the whole pipeline stalls under output backpressure.
- Sits between operand FIFOs and the datapath accumulator.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32; product width is 2*WIDTH.
- STAGES, 2, number of pipeline register ranks; legal range 1..4; latency in cycles equals STAGES.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands present on x/y.
- in_ready  output  1  block can accept operands this cycle.
- x  input  WIDTH  multiplicand.
- y  input  WIDTH  multiplier.
- out_valid  output  1  product present on o.
- out_ready  input  1  consumer accepts o this cycle.
- o  output  2*WIDTH  product x*y.

Behaviour:
- Reset: one clock, clk; reset rst_n is asynchronous and active-low. While rst_n=0, all stage valid bits and all data registers clear to 0, so out_valid=0 and o=0. Deassertion is synchronised externally. A reset mid-operation discards every in-flight product; none is ever emitted.
- Transfer rules: an input transfer occurs when in_valid && in_ready. An output transfer occurs when out_valid && out_ready.
- Stall signal: stall = out_valid && !out_ready.
- in_ready = !stall. It is purely combinational from out_ready and the last-stage valid, with no path from in_valid.
- Pipeline advance: on each non-stalled edge, every rank loads from the previous rank. Rank 0 loads from the input, with valid = in_valid. On a stalled edge every rank holds.
- Bubbles are not squeezed out. Throughput is one product per cycle when out_ready is held at 1.
- Latency: a product accepted at edge N appears with out_valid=1 after edge N+STAGES-1 when there are no stalls. With STAGES=1 the single rank registers the final sum.
- Order: strictly in order, with no loss and no duplication across any stall pattern.
- Arithmetic: o = x*y as an exact 2*WIDTH-bit unsigned result, so no overflow is possible.
- Reduction tree: partial-product columns are reduced with HA/FA cells until every column holds at most 2 bits, then added in a 2*WIDTH-bit adder.
- Register placement: pipeline ranks are placed after reduction levels ceil(k*L/STAGES) for k=1..STAGES-1, where L is the number of tree levels. The final rank follows the adder.
- Data registers of invalid ranks may load freely, but o must read 0 whenever out_valid=0. A gate on the output mux is acceptable.
- Output stability: while stall=1, o and out_valid remain stable.
- Simultaneous events: in_valid=1, out_valid=1 and out_ready=1 in the same cycle means both transfers happen and the pipeline shifts.

Optional Feature:
- Macro: PIPELINED_MULT_SIGNED_EN.
- When defined: an extra input port sgn (1 bit) travels alongside the operands through every rank.
  - sgn=1 treats x and y as two's complement and produces the signed 2*WIDTH-bit product. This uses Baugh-Wooley inversion of the MSB partial products plus correction constants.
  - sgn=0 gives an unsigned product.
- When undefined: the sgn port is absent and the block is unsigned only, with identical timing.

Test Plan:
- WIDTH=4, STAGES=2, out_ready=1; send x=15,y=15 then x=0,y=9 back-to-back -> o=225 (0xE1) then o=0 on consecutive cycles, each 2 cycles after acceptance.
- WIDTH=4, STAGES=2; stream all 256 operand pairs with out_ready=1 -> 256 products in order, each equal to x*y, one per cycle, with no gaps after fill.
- Random out_ready (50%) with x=7,y=6 then x=13,y=11 -> outputs 42 then 143 in order; o held stable and in_ready=0 during every stall cycle.
- Assert rst_n=0 for 1 cycle while 2 products are in flight -> out_valid=0 and o=0 immediately (asynchronous); no stale product after release.
- WIDTH=8, STAGES=4: x=255,y=255 -> o=65025 after exactly 4 cycles; x=128,y=2 -> o=256.
- With PIPELINED_MULT_SIGNED_EN, WIDTH=4: sgn=1, x=4'hF(-1), y=4'h7 -> o=8'hF9 (-7); sgn=1, x=8, y=8 (-8*-8) -> o=64; sgn=0, x=15, y=15 -> o=225.
